// File: rtl/val2_pkg.sv
// Shared types for the operand-2 shifter pipeline.
// Amount field is 8 bits, so DATA_W up to 128 is representable.
package val2_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_t;

    typedef enum logic [1:0] {
        M_MEM,
        M_IMM,
        M_REG,
        M_ISH
    } mode_t;

    typedef struct packed {
        mode_t       mode;
        shift_t      ty;
        logic [7:0]  amt;
        logic        carry;
    } s1_t;

    // ROR keeps a nonzero multiple of w as w; other types saturate at w+1.
    function automatic logic [7:0] eff_amt(
        input logic [7:0] n,
        input shift_t     ty,
        input logic [7:0] w
    );
        logic [7:0] r;
        r = n & (w - 8'd1);
        if (ty == SH_ROR)
            eff_amt = (n != 8'd0 && r == 8'd0) ? w : r;
        else
            eff_amt = (n > w) ? w + 8'd1 : n;
    endfunction

endpackage

// File: rtl/val2_shifter_pipe_if.sv
// Operand bundle in, operand-2 result out, each with valid/ready.
interface val2_shifter_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rm;
    logic [DATA_W-1:0] rs;
    logic [11:0]       shift_operand;
    logic              imm;
    logic              reg_shift;
    logic              mem_en;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val_2;
    logic              carry_out;

    modport master (
        output in_valid, rm, rs, shift_operand,
        output imm, reg_shift, mem_en, carry_in, out_ready,
        input  in_ready, out_valid, val_2, carry_out
    );

    modport slave (
        input  in_valid, rm, rs, shift_operand,
        input  imm, reg_shift, mem_en, carry_in, out_ready,
        output in_ready, out_valid, val_2, carry_out
    );
endinterface

// File: rtl/val2_shift_core.sv
// Combinational shifter: amount 0 is pass-through (or RRX), 1..W+1 shifts.
module val2_shift_core
    import val2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rm,
    input  logic              carry_in,
    input  shift_t            ty,
    input  logic [7:0]        amt,
    input  mode_t             mode,
    output logic [DATA_W-1:0] val_2,
    output logic              carry_out
);
    localparam int W = DATA_W;

    logic [2*W-1:0] lsl_w;
    logic [2*W-1:0] lsr_w;
    logic [2*W-1:0] asr_w;
    logic [2*W-1:0] ror_w;

    // Double-width shifts expose the last bit shifted out at a fixed index.
    always_comb begin
        lsl_w = {{W{1'b0}}, rm} << amt;
        lsr_w = {rm, {W{1'b0}}} >> amt;
        asr_w = $signed({rm, {W{1'b0}}}) >>> amt;
        ror_w = {rm, rm} >> amt;
        val_2 = rm;
        carry_out = carry_in;
        if (amt == 8'd0) begin
            if (mode == M_ISH && ty == SH_ROR) begin
                val_2 = {carry_in, rm[W-1:1]};
                carry_out = rm[0];
            end
        end else begin
            unique case (ty)
                SH_LSL: begin
                    val_2 = lsl_w[W-1:0];
                    carry_out = lsl_w[W];
                end
                SH_LSR: begin
                    val_2 = lsr_w[2*W-1:W];
                    carry_out = lsr_w[W-1];
                end
                SH_ASR: begin
                    val_2 = asr_w[2*W-1:W];
                    carry_out = asr_w[W-1];
                end
                SH_ROR: begin
                    val_2 = ror_w[W-1:0];
                    carry_out = ror_w[W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/val2_shifter_pipe.sv
// Two-stage operand-2 generator: S1 resolves mode/amount, S2 shifts.
module val2_shifter_pipe
    import val2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    val2_shifter_pipe_if.slave bus
);
    localparam logic [7:0] W8  = 8'(DATA_W);
    localparam logic [7:0] MSK = 8'(DATA_W - 1);

    logic              s1_valid;
    logic              s2_valid;
    s1_t               s1_q;
    logic [DATA_W-1:0] s1_rm;
    logic [DATA_W-1:0] s2_val;
    logic              s2_carry;

    logic              s2_load;
    logic              in_ready;
    shift_t            ty;
    mode_t             mode;
    logic [7:0]        ish_n;
    logic [7:0]        rot;
    s1_t               d;
    logic [DATA_W-1:0] d_rm;
    logic [DATA_W-1:0] core_val;
    logic              core_carry;
    logic              rs_unused;

    assign rs_unused = ^bus.rs[DATA_W-1:8];

    assign s2_load  = !s2_valid || bus.out_ready;
    assign in_ready = !flush && (!s1_valid || s2_load);

    always_comb begin
        ty = shift_t'(bus.shift_operand[6:5]);
        if (bus.mem_en)
            mode = M_MEM;
        else if (bus.imm)
            mode = M_IMM;
        else if (bus.reg_shift)
            mode = M_REG;
        else
            mode = M_ISH;
        // LSR/ASR #0 encode a full-width shift.
        ish_n = {3'b0, bus.shift_operand[11:7]};
        if (ish_n == 8'd0 && (ty == SH_LSR || ty == SH_ASR))
            ish_n = W8;
        rot = {3'b0, bus.shift_operand[11:8], 1'b0};
        d = '0;
        d.mode = mode;
        d.carry = bus.carry_in;
        d_rm = bus.rm;
        unique case (mode)
            M_MEM: begin
                d.ty = SH_LSL;
                d.amt = 8'd0;
                d_rm = DATA_W'(bus.shift_operand);
            end
            M_IMM: begin
                d.ty = SH_ROR;
                d.amt = rot & MSK;
                d_rm = DATA_W'(bus.shift_operand[7:0]);
            end
            M_REG: begin
                d.ty = ty;
                d.amt = eff_amt(bus.rs[7:0], ty, W8);
            end
            default: begin
                d.ty = ty;
                d.amt = eff_amt(ish_n, ty, W8);
            end
        endcase
    end

    val2_shift_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .rm       (s1_rm),
        .carry_in (s1_q.carry),
        .ty       (s1_q.ty),
        .amt      (s1_q.amt),
        .mode     (s1_q.mode),
        .val_2    (core_val),
        .carry_out(core_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s1_rm    <= '0;
            s2_val   <= '0;
            s2_carry <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_val   <= core_val;
                    s2_carry <= core_carry;
                end
            end
            if (in_ready)
                s1_valid <= bus.in_valid;
            if (bus.in_valid && in_ready) begin
                s1_q  <= d;
                s1_rm <= d_rm;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.val_2     = s2_val;
    assign bus.carry_out = s2_carry;

endmodule
